// File: rtl/branch_resolver_pkg.sv
// Shared types and constants for the branch resolver and its prediction queue.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package branch_resolver_pkg;

   // Width of the target field stored per in-flight branch.
   localparam int ADDR_W = 32;
   // Sequential-fetch increment used for the fall-through PC.
   localparam int PC_INC = 4;
   // Width of the resolved/mispredict statistics counters.
   localparam int CNT_W  = 32;

   // One queued prediction: what the predictor guessed at fetch time.
   typedef struct packed {
      logic              pred_taken;
      logic [ADDR_W-1:0] pred_target;
   } entry_t;

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } state_t;

endpackage

// File: rtl/branch_resolver_pred_queue.sv
// In-order FIFO of predictions for branches between IF and EX.
// Latency: head is combinational from storage; push visible at head the cycle after.
// Backpressure: none internally; the caller must not push when full unless it also pops.
//
// Ports: clk, rst_n (async active-low), push/push_dat (enqueue), pop (dequeue head),
//        clear (drop all entries, wins over push), head, count, full, empty.
module pred_queue
   import branch_resolver_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int QCNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  entry_t            push_dat,
   input  logic              pop,
   input  logic              clear,
   output entry_t            head,
   output logic [QCNT_W-1:0] count,
   output logic              full,
   output logic              empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   entry_t            mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   // Storage carries no reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push && !clear) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + QCNT_W'(1);
            2'b01:   count <= count - QCNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == QCNT_W'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/branch_resolver.sv
// Compares queued fetch-time predictions with EX outcomes; redirects and flushes on mispredict.
// Latency: 1 cycle from EX resolve to update/redirect/flush outputs.
// Backpressure: if_stall holds IF when the queue is full and nothing pops this cycle.
//
// Ports: clk, rst_n (async active-low); IF side if_valid/if_is_branch/if_pred_taken/
//        if_pred_target, if_stall; EX side ex_valid/ex_is_branch/ex_taken/ex_target/ex_pc;
//        outputs redirect_valid/redirect_pc, flush, upd_is_branch/upd_taken,
//        branch_cnt, mispred_cnt, err_underflow.
module branch_resolver
   import branch_resolver_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int DEPTH     = 4,
   parameter int FLUSH_LEN = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             if_valid,
   input  logic             if_is_branch,
   input  logic             if_pred_taken,
   input  logic [XLEN-1:0]  if_pred_target,
   input  logic             ex_valid,
   input  logic             ex_is_branch,
   input  logic             ex_taken,
   input  logic [XLEN-1:0]  ex_target,
   input  logic [XLEN-1:0]  ex_pc,
   output logic             if_stall,
   output logic             redirect_valid,
   output logic [XLEN-1:0]  redirect_pc,
   output logic             flush,
   output logic             upd_is_branch,
   output logic             upd_taken,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispred_cnt,
   output logic             err_underflow
);

   localparam int QCNT_W = $clog2(DEPTH + 1);
   localparam int FC_W   = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

   state_t            state;
   logic [FC_W-1:0]   flush_cnt;

   entry_t            q_head;
   entry_t            q_push_dat;
   logic [QCNT_W-1:0] q_count;
   logic              q_full;
   logic              q_empty;

   logic              resolve;
   logic              pop;
   logic              push;
   logic              mispred;
   logic              pred_taken;
   logic [XLEN-1:0]   pred_target;
   logic [XLEN-1:0]   correct_pc;

   // Resolves and pushes are only honoured outside the flush window.
   assign resolve = ex_valid & ex_is_branch & (state == IDLE);
   assign pop     = resolve & ~q_empty;

   // An EX branch with nothing queued is compared as a not-taken guess.
   assign pred_taken  = q_empty ? 1'b0 : q_head.pred_taken;
   assign pred_target = XLEN'(q_head.pred_target);

   assign mispred = resolve &
                    ((pred_taken != ex_taken) |
                     (pred_taken & ex_taken & (pred_target != ex_target)));

   // Fall-through wraps modulo 2^XLEN by construction.
   assign correct_pc = ex_taken ? ex_target : (ex_pc + XLEN'(PC_INC));

   // A full queue still accepts a push when the head leaves in the same cycle.
   assign push     = if_valid & if_is_branch & (state == IDLE) &
                     ((q_count < QCNT_W'(DEPTH)) | pop);
   assign if_stall = q_full & if_valid & if_is_branch & ~pop;

   assign q_push_dat.pred_taken  = if_pred_taken;
   assign q_push_dat.pred_target = ADDR_W'(if_pred_target);

   // Mispredict clears every entry, including a push in the same cycle:
   // all of them are younger than the resolving branch, hence wrong-path.
   pred_queue #(
      .DEPTH (DEPTH),
      .QCNT_W(QCNT_W)
   ) u_queue (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .push_dat(q_push_dat),
      .pop     (pop),
      .clear   (mispred),
      .head    (q_head),
      .count   (q_count),
      .full    (q_full),
      .empty   (q_empty)
   );

   // Control FSM with registered redirect/flush/update outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         flush_cnt      <= '0;
         flush          <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         upd_is_branch  <= 1'b0;
         upd_taken      <= 1'b0;
      end else begin
         upd_is_branch  <= resolve;
         upd_taken      <= resolve & ex_taken;
         redirect_valid <= mispred;
         if (mispred) begin
            redirect_pc <= correct_pc;
         end
         case (state)
            IDLE: begin
               if (mispred) begin
                  state     <= FLUSH;
                  flush_cnt <= FC_W'(FLUSH_LEN - 1);
                  flush     <= 1'b1;
               end else begin
                  flush     <= 1'b0;
               end
            end
            FLUSH: begin
               // flush was raised on entry; keep it while cycles remain.
               if (flush_cnt == '0) begin
                  state <= IDLE;
                  flush <= 1'b0;
               end else begin
                  flush_cnt <= flush_cnt - FC_W'(1);
                  flush     <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               flush <= 1'b0;
            end
         endcase
      end
   end

   // Statistics and sticky error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_cnt    <= '0;
         mispred_cnt   <= '0;
         err_underflow <= 1'b0;
      end else begin
         if (resolve && (branch_cnt != '1)) begin
            branch_cnt <= branch_cnt + CNT_W'(1);
         end
         if (mispred && (mispred_cnt != '1)) begin
            mispred_cnt <= mispred_cnt + CNT_W'(1);
         end
         if (resolve && q_empty) begin
            err_underflow <= 1'b1;
         end
      end
   end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Resolves branches at the other end of the 2-bit predictor.
- Records each fetched branch's prediction in an in-order queue and compares it against the EX-stage outcome.
- On a misprediction it generates the PC redirect and a pipeline flush.
- Returns the resolved outcome (update is_branch/taken) to the predictor.

Parameters:
XLEN, 32, address/PC width
DEPTH, 4, max in-flight predicted branches (power of 2, >=2)
FLUSH_LEN, 2, cycles flush is held after a mispredict (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_valid  in  1  IF stage holds a valid instruction
if_is_branch  in  1  IF instruction is a conditional branch
if_pred_taken  in  1  predictor guess for this branch
if_pred_target  in  XLEN  target fetched from if predicted taken
ex_valid  in  1  EX stage holds a valid instruction
ex_is_branch  in  1  EX instruction is a conditional branch
ex_taken  in  1  actual branch outcome
ex_target  in  XLEN  actual taken target
ex_pc  in  XLEN  PC of EX branch
if_stall  out  1  queue full, IF must hold the branch
redirect_valid  out  1  one-cycle redirect pulse
redirect_pc  out  XLEN  correct next PC
flush  out  1  kill IF/ID/EX younger instructions
upd_is_branch  out  1  to predictor is_branch
upd_taken  out  1  to predictor Branch_taken
branch_cnt  out  32  resolved branches, saturating
mispred_cnt  out  32  mispredicts, saturating
err_underflow  out  1  sticky: EX branch arrived with empty queue

Behaviour:
- Reset (rst_n=0, async): queue emptied, state IDLE, all outputs 0, counters 0.
- Push: if_valid & if_is_branch & state==IDLE & (count<DEPTH or pop this cycle).
  - Entry = {pred_taken, pred_target}.
- if_stall = (count==DEPTH) & if_valid & if_is_branch & no pop this cycle. Combinational.
- Pop/resolve: ex_valid & ex_is_branch & state==IDLE pops the head entry.
- Empty queue at resolve: no pop, compare against pred_taken=0, set err_underflow (cleared only by reset).
- Mispredict when either holds:
  - pred_taken != ex_taken, or
  - both taken and pred_target != ex_target.
- Correct PC = ex_taken ? ex_target : ex_pc+4. The +4 is computed modulo 2^XLEN (wraps).
- Outputs registered; latency 1 cycle after resolve:
  - upd_is_branch=1 and upd_taken=ex_taken for exactly one cycle for every resolved branch.
  - branch_cnt increments; mispred_cnt increments on mispredict. Both saturate at 0xFFFFFFFF.
- On mispredict, the next cycle:
  - redirect_valid=1 for one cycle, with redirect_pc.
  - flush=1 for exactly FLUSH_LEN consecutive cycles.
  - Queue cleared, since all younger entries are wrong-path.
- FSM:
  - IDLE -> FLUSH on mispredict; flush counter loaded with FLUSH_LEN-1.
  - FLUSH counts down, returns to IDLE when the counter is 0.
  - In FLUSH, pushes and resolves are ignored: no pop, no update, no count.
- Simultaneous push and mispredict in the same cycle: push discarded and queue empty afterwards.
- Simultaneous push and correct resolve: both happen, count unchanged.
- redirect_pc holds its last value when redirect_valid=0.

Decomposition:
- Package branch_resolver_pkg holds:
  - entry typedef {pred_taken, pred_target}
  - state enum {IDLE, FLUSH}
  - PC_INC=4 constant
  - counter width constant
- One sub-module, pred_queue: synchronous FIFO with DEPTH entries, DEPTH of type entry.
  - Signals: push, pop, clear, head, count, full, empty.
  - Async active-low reset; clear has priority over push.

Test Plan:
- Correct not-taken: push pred=0, resolve ex_taken=0, ex_pc=0x100.
  - Next cycle upd_is_branch=1, upd_taken=0, redirect_valid=0, branch_cnt=1, mispred_cnt=0.
- Direction mispredict: push pred=0, resolve ex_taken=1, ex_target=0x200.
  - Next cycle redirect_valid=1, redirect_pc=0x200.
  - flush high 2 cycles, queue empty, mispred_cnt=1.
- Fall-through mispredict plus younger entries: push 3 branches pred=1; first resolves ex_taken=0, ex_pc=0xFFFFFFFC.
  - redirect_pc=0x00000000 (wraps), queue count=0.
  - EX branch during flush cycles causes no update.
- Full queue: push 4 branches with no resolve.
  - 5th branch sees if_stall=1.
  - Same cycle with a correct resolve: if_stall=0 and count stays 4.
- Underflow: resolve ex_taken=1, ex_target=0x40 with empty queue.
  - err_underflow=1 (sticky), redirect_pc=0x40.
  - Then rst_n low mid-flush clears flush, err_underflow and counters immediately.
